// File: rtl/vending_machine_core_param_pkg.sv
// vending_machine_core_param_pkg: shared state encoding for the vending core
package vending_machine_core_param_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RETURN = 2'd2
   } state_e;
endpackage

// File: rtl/vending_machine_core_param_change_selector.sv
// vending_machine_core_param_change_selector: greedy pick of the largest coin not exceeding the credit
module vending_machine_core_param_change_selector #(
   parameter int NUM_COINS  = 3,
   parameter int TOTAL_BITS = 31
) (
   input  logic [TOTAL_BITS-1:0]           total_i,
   input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value_i,
   output logic [NUM_COINS-1:0]            coin_o,
   output logic [TOTAL_BITS-1:0]           value_o,
   output logic                            none_o
);
   // coins ascend by index, so the last fitting coin scanned is the largest
   always_comb begin
      coin_o  = '0;
      value_o = '0;
      none_o  = 1'b1;
      for (int i = 0; i < NUM_COINS; i++) begin
         if (coin_value_i[i*TOTAL_BITS +: TOTAL_BITS] <= total_i) begin
            coin_o  = NUM_COINS'(1) << i;
            value_o = coin_value_i[i*TOTAL_BITS +: TOTAL_BITS];
            none_o  = 1'b0;
         end
      end
   end
endmodule

// File: rtl/vending_machine_core_param.sv
// vending_machine_core_param: parametrised credit, stock, idle-timeout and change-return engine
module vending_machine_core_param
   import vending_machine_core_param_pkg::*;
#(
   parameter int NUM_COINS   = 3,
   parameter int NUM_ITEMS   = 4,
   parameter int TOTAL_BITS  = 31,
   parameter int MAX_TOTAL   = 2000,
   parameter int WAIT_CYCLES = 100,
   parameter int STOCK_BITS  = 4,
   parameter int INIT_STOCK  = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_COINS*TOTAL_BITS-1:0]  i_coin_value,
   input  logic [NUM_ITEMS*TOTAL_BITS-1:0]  i_item_price,
   input  logic [NUM_COINS-1:0]             i_input_coin,
   input  logic [NUM_ITEMS-1:0]             i_select_item,
   input  logic                             i_trigger_return,
   input  logic                             i_restock_valid,
   input  logic [$clog2(NUM_ITEMS)-1:0]     i_restock_item,
   input  logic [STOCK_BITS-1:0]            i_restock_qty,
   output logic [TOTAL_BITS-1:0]            o_current_total,
   output logic [NUM_ITEMS-1:0]             o_available_item,
   output logic [NUM_ITEMS-1:0]             o_output_item,
   output logic [NUM_COINS-1:0]             o_return_coin,
   output logic                             o_select_nack,
   output logic                             o_coin_reject,
   output logic                             o_busy,
   output logic                             o_return_done,
   output logic [TOTAL_BITS-1:0]            o_residue,
   output logic [NUM_ITEMS*STOCK_BITS-1:0]  o_stock
);
   localparam int SUM_W = TOTAL_BITS + $clog2(NUM_COINS + 1) + 1;
   localparam int CNT_W = $clog2(WAIT_CYCLES + 1) > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IDX_W = $clog2(NUM_ITEMS);
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
   localparam logic [STOCK_BITS:0] STOCK_MAX = {1'b0, {STOCK_BITS{1'b1}}};

   state_e                          state_q, state_d;
   logic [TOTAL_BITS-1:0]           total_q, total_d;
   logic [TOTAL_BITS-1:0]           residue_q, residue_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [NUM_ITEMS*STOCK_BITS-1:0] stock_q, stock_d;
   logic [NUM_ITEMS-1:0]            item_q;
   logic [NUM_COINS-1:0]            ret_q, ret_d;
   logic                            nack_q, rej_q, done_q, done_d;
   logic [NUM_ITEMS-1:0]            sel_oh;
   logic [TOTAL_BITS-1:0]           sel_price, chg_value;
   logic [STOCK_BITS-1:0]           sel_stock;
   logic [NUM_COINS-1:0]            chg_coin;
   logic                            chg_none;
   logic [SUM_W-1:0]                coin_sum;
   logic [STOCK_BITS:0]             stock_tmp;
   logic                            active, trig, coin_ok, vend;

   vending_machine_core_param_change_selector #(
      .NUM_COINS  (NUM_COINS),
      .TOTAL_BITS (TOTAL_BITS)
   ) u_chg (
      .total_i      (total_q),
      .coin_value_i (i_coin_value),
      .coin_o       (chg_coin),
      .value_o      (chg_value),
      .none_o       (chg_none)
   );

   // value of every coin inserted this cycle
   always_comb begin
      coin_sum = '0;
      for (int i = 0; i < NUM_COINS; i++)
         if (i_input_coin[i]) coin_sum = coin_sum + SUM_W'(i_coin_value[i*TOTAL_BITS +: TOTAL_BITS]);
   end

   // lowest-index requested item wins
   always_comb begin
      sel_oh    = '0;
      sel_price = '0;
      sel_stock = '0;
      for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
         if (i_select_item[i]) begin
            sel_oh    = NUM_ITEMS'(1) << i;
            sel_price = i_item_price[i*TOTAL_BITS +: TOTAL_BITS];
            sel_stock = stock_q[i*STOCK_BITS +: STOCK_BITS];
         end
      end
   end

   assign active  = state_q == ST_ACTIVE;
   assign trig    = active && i_trigger_return;
   assign coin_ok = |i_input_coin && state_q != ST_RETURN && !trig &&
                    SUM_W'(total_q) + coin_sum <= SUM_W'(MAX_TOTAL);
   assign vend    = active && !i_trigger_return && |i_select_item &&
                    sel_price <= total_q && sel_stock != '0;

   genvar g;
   for (g = 0; g < NUM_ITEMS; g++) begin : g_avail
      assign o_available_item[g] = active &&
                                   i_item_price[g*TOTAL_BITS +: TOTAL_BITS] <= total_q &&
                                   stock_q[g*STOCK_BITS +: STOCK_BITS] != '0;
   end

   // credit, idle timer and change-return sequencing
   always_comb begin
      state_d   = state_q;
      total_d   = total_q;
      cnt_d     = cnt_q;
      ret_d     = '0;
      done_d    = 1'b0;
      residue_d = residue_q;
      if (state_q == ST_RETURN) begin
         if (chg_none) begin
            done_d    = 1'b1;
            residue_d = total_q;
            total_d   = '0;
            state_d   = ST_IDLE;
         end else begin
            ret_d   = chg_coin;
            total_d = total_q - chg_value;
         end
      end else if (trig) begin
         state_d = ST_RETURN;
      end else if (coin_ok || vend) begin
         total_d = TOTAL_BITS'(SUM_W'(total_q) + (coin_ok ? coin_sum : '0) - (vend ? SUM_W'(sel_price) : '0));
         cnt_d   = WAIT_LD;
         state_d = total_d == '0 ? ST_IDLE : ST_ACTIVE;
      end else if (active) begin
         cnt_d   = cnt_q - CNT_W'(1);
         state_d = cnt_q <= CNT_W'(1) ? ST_RETURN : ST_ACTIVE;
      end
   end

   // per-item stock: restock adds, vend subtracts, result saturates at the counter maximum
   always_comb begin
      stock_d   = stock_q;
      stock_tmp = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         stock_tmp = {1'b0, stock_q[i*STOCK_BITS +: STOCK_BITS]}
                   + (i_restock_valid && i_restock_item == IDX_W'(i) ? {1'b0, i_restock_qty} : '0)
                   - (vend && sel_oh[i] ? (STOCK_BITS + 1)'(1) : '0);
         stock_d[i*STOCK_BITS +: STOCK_BITS] = stock_tmp > STOCK_MAX ? STOCK_MAX[STOCK_BITS-1:0]
                                                                     : stock_tmp[STOCK_BITS-1:0];
      end
   end

   // state, credit, stock and registered pulse outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         total_q   <= '0;
         cnt_q     <= '0;
         residue_q <= '0;
         stock_q   <= {NUM_ITEMS{STOCK_BITS'(INIT_STOCK)}};
         item_q    <= '0;
         ret_q     <= '0;
         nack_q    <= 1'b0;
         rej_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         total_q   <= total_d;
         cnt_q     <= cnt_d;
         residue_q <= residue_d;
         stock_q   <= stock_d;
         item_q    <= vend ? sel_oh : '0;
         ret_q     <= ret_d;
         nack_q    <= |i_select_item && !vend;
         rej_q     <= |i_input_coin && !coin_ok;
         done_q    <= done_d;
      end
   end

   assign o_current_total = total_q;
   assign o_output_item   = item_q;
   assign o_return_coin   = ret_q;
   assign o_select_nack   = nack_q;
   assign o_coin_reject   = rej_q;
   assign o_busy          = state_q == ST_RETURN;
   assign o_return_done   = done_q;
   assign o_residue       = residue_q;
   assign o_stock         = stock_q;
endmodule

// File: tb/tb_vending_machine_core_param.sv
// tb_vending_machine_core_param: directed scenarios plus random traffic against a transaction-level model
module tb_vending_machine_core_param;
   localparam int TB   = 31;
   localparam int WAIT = 8;
   localparam int MAXT = 2000;
   localparam int SMAX = 15;
   localparam int INIT = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [3*TB-1:0] i_coin_value;
   logic [4*TB-1:0] i_item_price;
   logic [2:0]      i_input_coin = '0;
   logic [3:0]      i_select_item = '0;
   logic            i_trigger_return = 1'b0;
   logic            i_restock_valid = 1'b0;
   logic [1:0]      i_restock_item = '0;
   logic [3:0]      i_restock_qty = '0;
   logic [TB-1:0]   o_current_total;
   logic [3:0]      o_available_item;
   logic [3:0]      o_output_item;
   logic [2:0]      o_return_coin;
   logic            o_select_nack;
   logic            o_coin_reject;
   logic            o_busy;
   logic            o_return_done;
   logic [TB-1:0]   o_residue;
   logic [15:0]     o_stock;

   int coin_val[3] = '{100, 500, 1000};
   int price[4] = '{400, 500, 1000, 2000};
   int shelf[4];
   int credit, mode, patience, res;
   int payout[$];
   int e_item, e_ret;
   bit e_nack, e_rej, e_done;
   int n_cmp = 0;
   int n_bad = 0;

   assign i_coin_value = {TB'(coin_val[2]), TB'(coin_val[1]), TB'(coin_val[0])};
   assign i_item_price = {TB'(price[3]), TB'(price[2]), TB'(price[1]), TB'(price[0])};

   vending_machine_core_param #(
      .WAIT_CYCLES (WAIT),
      .MAX_TOTAL   (MAXT),
      .INIT_STOCK  (INIT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .i_coin_value     (i_coin_value),
      .i_item_price     (i_item_price),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .i_restock_valid  (i_restock_valid),
      .i_restock_item   (i_restock_item),
      .i_restock_qty    (i_restock_qty),
      .o_current_total  (o_current_total),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_select_nack    (o_select_nack),
      .o_coin_reject    (o_coin_reject),
      .o_busy           (o_busy),
      .o_return_done    (o_return_done),
      .o_residue        (o_residue),
      .o_stock          (o_stock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_avail();
      logic [3:0] a = '0;
      for (int j = 0; j < 4; j++) a[j] = mode == 1 && price[j] <= credit && shelf[j] > 0;
      return a;
   endfunction

   function automatic logic [15:0] exp_stock();
      logic [15:0] s = '0;
      for (int j = 0; j < 4; j++) s[j*4 +: 4] = 4'(shelf[j]);
      return s;
   endfunction

   task automatic model_reset();
      credit = 0;
      mode = 0;
      patience = 0;
      res = 0;
      payout.delete();
      foreach (shelf[j]) shelf[j] = INIT;
      e_item = 0;
      e_ret = 0;
      e_nack = 0;
      e_rej = 0;
      e_done = 0;
   endtask

   // change is the greedy decomposition of the credit, paid out one coin per cycle
   task automatic enter_return();
      int c = credit;
      mode = 2;
      payout.delete();
      for (int j = 2; j >= 0; j--)
         while (c >= coin_val[j]) begin
            payout.push_back(j);
            c -= coin_val[j];
         end
   endtask

   task automatic check_all();
      chk("total", 64'(o_current_total), 64'(credit));
      chk("item", 64'(o_output_item), 64'(e_item));
      chk("ret", 64'(o_return_coin), 64'(e_ret));
      chk("nack", 64'(o_select_nack), 64'(e_nack));
      chk("reject", 64'(o_coin_reject), 64'(e_rej));
      chk("busy", 64'(o_busy), 64'(mode == 2));
      chk("done", 64'(o_return_done), 64'(e_done));
      chk("residue", 64'(o_residue), 64'(res));
      chk("stock", 64'(o_stock), 64'(exp_stock()));
   endtask

   task automatic step(input int coins, input int sel, input bit trig, input bit rv, input int ri, input int rq);
      int sum = 0;
      int k = -1;
      bit vend = 1'b0;
      bit ok, tr;
      i_input_coin = 3'(coins);
      i_select_item = 4'(sel);
      i_trigger_return = trig;
      i_restock_valid = rv;
      i_restock_item = 2'(ri);
      i_restock_qty = 4'(rq);
      #1;
      chk("avail", 64'(o_available_item), 64'(exp_avail()));
      for (int j = 0; j < 3; j++) if (coins[j]) sum += coin_val[j];
      for (int j = 3; j >= 0; j--) if (sel[j]) k = j;
      e_item = 0;
      e_ret = 0;
      e_nack = 0;
      e_rej = 0;
      e_done = 0;
      if (mode == 2) begin
         e_rej = coins != 0;
         e_nack = sel != 0;
         if (payout.size() > 0) begin
            e_ret = 1 << payout[0];
            credit -= coin_val[payout[0]];
            void'(payout.pop_front());
         end else begin
            e_done = 1;
            res = credit;
            credit = 0;
            mode = 0;
         end
      end else begin
         tr = mode == 1 && trig;
         vend = mode == 1 && !trig && k >= 0 && price[k] <= credit && shelf[k] > 0;
         ok = coins != 0 && !tr && credit + sum <= MAXT;
         e_nack = sel != 0 && !vend;
         e_rej = coins != 0 && !ok;
         if (vend) e_item = 1 << k;
         if (tr) enter_return();
         else if (ok || vend) begin
            credit += (ok ? sum : 0) - (vend ? price[k] : 0);
            patience = WAIT;
            mode = credit > 0 ? 1 : 0;
         end else if (mode == 1) begin
            patience--;
            if (patience == 0) enter_return();
         end
      end
      for (int j = 0; j < 4; j++) begin
         shelf[j] += (rv && ri == j ? rq : 0) - (vend && k == j ? 1 : 0);
         if (shelf[j] > SMAX) shelf[j] = SMAX;
      end
      @(posedge clk);
      #1;
      check_all();
      i_input_coin = '0;
      i_select_item = '0;
      i_trigger_return = 1'b0;
      i_restock_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_avail", 64'(o_available_item), 64'(0));
      reset = 1'b0;
      // insert 500 then 1000, vend item1
      step(2, 0, 0, 0, 0, 0);
      step(4, 0, 0, 0, 0, 0);
      chk("a_avail", 64'(o_available_item), 64'(4'b0111));
      step(0, 2, 0, 0, 0, 0);
      chk("a_total", 64'(o_current_total), 64'(1000));
      chk("a_vend", 64'(o_output_item), 64'(4'b0010));
      // unaffordable item, then empty the item0 slot and request it again
      step(0, 8, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(2, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("b_nack", 64'(o_select_nack), 64'(1));
      step(0, 0, 1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0, 0);
      // 1600 returned as 1000, 500, 100
      step(7, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("c_coin1000", 64'(o_return_coin), 64'(3'b100));
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("c_coin100", 64'(o_return_coin), 64'(3'b001));
      step(0, 0, 0, 0, 0, 0);
      chk("c_done", 64'(o_return_done), 64'(1));
      chk("c_idle", 64'(o_busy), 64'(0));
      // idle timeout, coin refused during return
      step(2, 0, 0, 0, 0, 0);
      repeat (8) step(0, 0, 0, 0, 0, 0);
      chk("d_busy", 64'(o_busy), 64'(1));
      step(1, 0, 0, 0, 0, 0);
      chk("d_reject", 64'(o_coin_reject), 64'(1));
      step(0, 0, 0, 0, 0, 0);
      // ceiling and coin+select in the same cycle
      step(7, 0, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      step(2, 0, 0, 0, 0, 0);
      chk("e_ceiling", 64'(o_current_total), 64'(1900));
      step(0, 0, 0, 1, 0, 3);
      step(1, 1, 0, 0, 0, 0);
      chk("e_total", 64'(o_current_total), 64'(1600));
      // asynchronous reset in the middle of a return
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #2;
      model_reset();
      check_all();
      chk("f_avail", 64'(o_available_item), 64'(0));
      reset = 1'b0;
      #1;
      // saturating restock, restock netted with a vend of the same item
      step(4, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 2, 15);
      step(0, 4, 0, 1, 2, 1);
      chk("g_stock2", 64'(o_stock[11:8]), 64'(15));
      step(0, 0, 1, 0, 0, 0);
      // uneven price to leave residue, zero-price item
      price[0] = 450;
      price[3] = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 100 >= 88) step(0, 0, 0, 0, 0, 0);
         else step($urandom_range(0, 9) < 3 ? int'($urandom_range(1, 7)) : 0,
                   $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 15)) : 0,
                   $urandom_range(0, 29) == 0,
                   $urandom_range(0, 9) == 0,
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)));
      end
      repeat (20) step(0, 0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
